// File: rtl/dense_fc_layer.sv
// dense_fc_layer: fixed-point fully-connected layer over M10K-resident vector, weights and biases
module dense_fc_layer #(
  parameter int DATA_WIDTH     = 27,
  parameter int FRACTION_WIDTH = 8,
  parameter int IN_LEN         = 50,
  parameter int OUT_LEN        = 10,
  parameter int ADDR_WIDTH     = 10,
  parameter int WADDR_WIDTH    = 10,
  parameter int READ_LATENCY   = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          run,
  input  logic signed [DATA_WIDTH-1:0]  vec_data_in,
  output logic        [ADDR_WIDTH-1:0]  vec_read_addr_out,
  input  logic signed [DATA_WIDTH-1:0]  weight_data_in,
  output logic        [WADDR_WIDTH-1:0] weight_read_addr_out,
  input  logic signed [DATA_WIDTH-1:0]  bias_data_in,
  output logic        [ADDR_WIDTH-1:0]  bias_read_addr_out,
  output logic signed [DATA_WIDTH-1:0]  result_out,
  output logic        [ADDR_WIDTH-1:0]  write_address_out,
  output logic                          we_out,
  output logic                          fc_done
);
  localparam int AW = 2*DATA_WIDTH + $clog2(IN_LEN) + 1;
  localparam logic [READ_LATENCY-1:0] LAST_TAG = READ_LATENCY'(1) << (READ_LATENCY-1);
  localparam logic signed [AW:0] SMAX = (AW+1)'({1'b0, {(DATA_WIDTH-1){1'b1}}});
  localparam logic signed [AW:0] SMIN = ~SMAX;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [ADDR_WIDTH-1:0] i_q, i_d, o_q, o_d, wa_q, wa_d;
  logic [WADDR_WIDTH-1:0] w_q, w_d;
  logic [READ_LATENCY-1:0] vld_q, vld_d;
  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0] res_q, res_d, sat;
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [AW:0] sum, shr;
  logic last_i, last_o, drained;
  assign last_i = i_q == ADDR_WIDTH'(IN_LEN-1);
  assign last_o = o_q == ADDR_WIDTH'(OUT_LEN-1);
  // the last tag sits alone at the pipe end exactly READ_LATENCY cycles after the final issue
  assign drained = vld_q == LAST_TAG;
  assign vec_read_addr_out = i_q;
  assign weight_read_addr_out = w_q;
  assign bias_read_addr_out = o_q;
  // state register
  always_ff @(posedge clk)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  // next-state logic; run only matters in IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = run ? FETCH : IDLE;
      FETCH:   state_d = last_i ? DRAIN : FETCH;
      DRAIN:   state_d = drained ? WRITE : DRAIN;
      WRITE:   state_d = last_o ? DONE : FETCH;
      default: state_d = IDLE;
    endcase
  end
  // outputs: live result during WRITE, otherwise the held copy of the last write
  always_comb begin
    we_out = state_q == WRITE;
    fc_done = state_q == DONE;
    result_out = state_q == WRITE ? sat : res_q;
    write_address_out = state_q == WRITE ? o_q : wa_q;
  end
  // MAC product, bias alignment, floor shift and saturation
  always_comb begin
    prod = vec_data_in * weight_data_in;
    sum = (AW+1)'(acc_q) + ((AW+1)'(bias_data_in) <<< FRACTION_WIDTH);
    shr = sum >>> FRACTION_WIDTH;
    sat = shr > SMAX ? DATA_WIDTH'(SMAX) : shr < SMIN ? DATA_WIDTH'(SMIN) : DATA_WIDTH'(shr);
  end
  // counters, running weight address, accumulator and read-tag pipe
  always_comb begin
    i_d = i_q;
    o_d = o_q;
    w_d = w_q;
    acc_d = vld_q[READ_LATENCY-1] ? acc_q + AW'(prod) : acc_q;
    vld_d = (vld_q << 1) | READ_LATENCY'(state_q == FETCH);
    res_d = state_q == WRITE ? sat : res_q;
    wa_d = state_q == WRITE ? o_q : wa_q;
    if (state_q == IDLE && run) begin
      i_d = '0;
      o_d = '0;
      w_d = '0;
      acc_d = '0;
    end
    if (state_q == FETCH && !last_i) begin
      i_d = i_q + 1'b1;
      w_d = w_q + 1'b1;
    end
    if (state_q == WRITE && !last_o) begin
      i_d = '0;
      o_d = o_q + 1'b1;
      w_d = w_q + 1'b1;
      acc_d = '0;
    end
  end
  // datapath registers
  always_ff @(posedge clk)
    if (reset) begin
      i_q <= '0;
      o_q <= '0;
      w_q <= '0;
      wa_q <= '0;
      acc_q <= '0;
      vld_q <= '0;
      res_q <= '0;
    end else begin
      i_q <= i_d;
      o_q <= o_d;
      w_q <= w_d;
      wa_q <= wa_d;
      acc_q <= acc_d;
      vld_q <= vld_d;
      res_q <= res_d;
    end
endmodule

// File: tb/tb_dense_fc_layer.sv
// tb_dense_fc_layer: directed checks of dense_fc_layer on small, deep-latency and default-size instances
module tb_dense_fc_layer;
  logic clk, reset, run_x;
  int cur, passed, total, nw, done_k;
  int rec_a[16], rec_k[16];
  longint rec_d[16];
  logic signed [26:0] vs[1024], ws[1024], bs[1024], vd[1024], wm[1024], bd[1024];
  logic signed [26:0] pa[3][3], pb[3][3], pc[3][3];
  logic signed [26:0] vin_a, win_a, bin_a, res_a, vin_b, win_b, bin_b, res_b, vin_c, win_c, bin_c, res_c, res_s;
  logic [9:0] va_a, wa_a, ba_a, wad_a, va_b, wa_b, ba_b, wad_b, va_c, wa_c, ba_c, wad_c, wad_s;
  logic run_a, run_b, run_c, we_a, we_b, we_c, dn_a, dn_b, dn_c, we_s, dn_s;
  dense_fc_layer #(.IN_LEN(4), .OUT_LEN(2)) dut_a (.clk(clk), .reset(reset), .run(run_a),
    .vec_data_in(vin_a), .vec_read_addr_out(va_a), .weight_data_in(win_a), .weight_read_addr_out(wa_a),
    .bias_data_in(bin_a), .bias_read_addr_out(ba_a), .result_out(res_a), .write_address_out(wad_a),
    .we_out(we_a), .fc_done(dn_a));
  dense_fc_layer #(.IN_LEN(4), .OUT_LEN(2), .READ_LATENCY(3)) dut_b (.clk(clk), .reset(reset), .run(run_b),
    .vec_data_in(vin_b), .vec_read_addr_out(va_b), .weight_data_in(win_b), .weight_read_addr_out(wa_b),
    .bias_data_in(bin_b), .bias_read_addr_out(ba_b), .result_out(res_b), .write_address_out(wad_b),
    .we_out(we_b), .fc_done(dn_b));
  dense_fc_layer dut_c (.clk(clk), .reset(reset), .run(run_c),
    .vec_data_in(vin_c), .vec_read_addr_out(va_c), .weight_data_in(win_c), .weight_read_addr_out(wa_c),
    .bias_data_in(bin_c), .bias_read_addr_out(ba_c), .result_out(res_c), .write_address_out(wad_c),
    .we_out(we_c), .fc_done(dn_c));
  initial clk = 0;
  always #5 clk = ~clk;
  assign run_a = run_x && cur == 0;
  assign run_b = run_x && cur == 1;
  assign run_c = run_x && cur == 2;
  assign we_s = cur == 0 ? we_a : cur == 1 ? we_b : we_c;
  assign dn_s = cur == 0 ? dn_a : cur == 1 ? dn_b : dn_c;
  assign res_s = cur == 0 ? res_a : cur == 1 ? res_b : res_c;
  assign wad_s = cur == 0 ? wad_a : cur == 1 ? wad_b : wad_c;
  // registered memory models: stage j holds data for an address presented j+1 cycles ago
  always @(posedge clk) begin
    pa[0][0] <= vs[va_a]; pa[1][0] <= ws[wa_a]; pa[2][0] <= bs[ba_a];
    pb[0][0] <= vs[va_b]; pb[1][0] <= ws[wa_b]; pb[2][0] <= bs[ba_b];
    pc[0][0] <= vd[va_c]; pc[1][0] <= wm[wa_c]; pc[2][0] <= bd[ba_c];
    for (int j = 1; j < 3; j++)
      for (int p = 0; p < 3; p++) begin
        pa[p][j] <= pa[p][j-1];
        pb[p][j] <= pb[p][j-1];
        pc[p][j] <= pc[p][j-1];
      end
  end
  assign vin_a = pa[0][1]; assign win_a = pa[1][1]; assign bin_a = pa[2][1];
  assign vin_b = pb[0][2]; assign win_b = pb[1][2]; assign bin_b = pb[2][2];
  assign vin_c = pc[0][1]; assign win_c = pc[1][1]; assign bin_c = pc[2][1];

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic set_small(input int v, input int w, input int b);
    for (int i = 0; i < 4; i++) vs[i] = 27'(v);
    for (int i = 0; i < 8; i++) ws[i] = 27'(w);
    for (int i = 0; i < 2; i++) bs[i] = 27'(b);
  endtask

  // pulse run on instance sel, record writes; returns at the negedge where fc_done is visible.
  // done_k counts clock edges from the edge sampling run to the edge sampling fc_done.
  task automatic do_run(input int sel, input bit repulse);
    int k;
    nw = 0;
    done_k = -1;
    for (int j = 0; j < 16; j++) begin rec_a[j] = -1; rec_d[j] = -1; rec_k[j] = -1; end
    cur = sel;
    @(negedge clk); run_x = 1;
    @(negedge clk); run_x = 0;
    k = 0;
    while (k < 700) begin
      if (we_s && nw < 16) begin rec_a[nw] = int'(wad_s); rec_d[nw] = res_s; rec_k[nw] = k; nw++; end
      if (dn_s) begin done_k = k + 1; break; end
      run_x = repulse && (k == 2 || k == 6);
      @(negedge clk);
      k++;
    end
    run_x = 0;
  endtask

  task automatic chk_small(input string t, input longint d0, input longint d1, input int per, input int dn);
    chk({t, "_nwrites"}, nw, 2);
    chk({t, "_addr0"}, rec_a[0], 0);
    chk({t, "_addr1"}, rec_a[1], 1);
    chk({t, "_res0"}, rec_d[0], d0);
    chk({t, "_res1"}, rec_d[1], d1);
    chk({t, "_period"}, rec_k[1] - rec_k[0], per);
    chk({t, "_done_lat"}, done_k, dn);
  endtask

  function automatic longint gold(input int o);
    longint s;
    s = 0;
    for (int i = 0; i < 50; i++) s += longint'(vd[i]) * longint'(wm[o*50+i]);
    s = (s + longint'(bd[o]) * 256) >>> 8;
    return s > 67108863 ? 67108863 : s < -67108864 ? -67108864 : s;
  endfunction

  initial begin
    int k, cnt;
    reset = 1; run_x = 0; cur = 0; passed = 0; total = 0;
    for (int i = 0; i < 1024; i++) begin vs[i] = 0; ws[i] = 0; bs[i] = 0; vd[i] = 0; wm[i] = 0; bd[i] = 0; end
    repeat (3) @(negedge clk);
    reset = 0;
    chk("rst_result", res_a, 0);
    chk("rst_waddr", wad_a, 0);
    chk("rst_we", we_a, 0);
    chk("rst_done", dn_a, 0);
    chk("rst_vaddr", va_a, 0);
    chk("rst_wtaddr", wa_a, 0);
    chk("rst_baddr", ba_a, 0);
    // 1.0 * 1.0 summed over 4 -> 4.0 = 1024
    set_small(256, 256, 0);
    do_run(0, 0);
    chk_small("ones", 1024, 1024, 7, 15);
    chk("hold_result", res_s, 1024);
    chk("hold_waddr", wad_s, 1);
    chk("hold_we", we_s, 0);
    // row/column addressing: row0 = 1+2+3+4 = 10.0 -> 2560, row1 = vec[0]*4.0 = 4.0 -> 1024
    for (int i = 0; i < 4; i++) begin vs[i] = 27'(256 * (i + 1)); ws[i] = 256; end
    ws[4] = 1024; ws[5] = 0; ws[6] = 0; ws[7] = 0;
    do_run(0, 0);
    chk_small("rows", 2560, 1024, 7, 15);
    // 4*(1.0*-0.5) + 0.25 = -1.75 -> -448; with bias -1.0 -> -3.0 -> -768
    set_small(256, -128, 64);
    bs[1] = -256;
    do_run(0, 0);
    chk_small("bias", -448, -768, 7, 15);
    // 4/256 floors to 0, -4/256 floors to -1
    set_small(1, 1, 0);
    do_run(0, 0);
    chk_small("floor_pos", 0, 0, 7, 15);
    set_small(1, -1, 0);
    do_run(0, 0);
    chk_small("floor_neg", -1, -1, 7, 15);
    set_small(67108863, 67108863, 0);
    do_run(0, 0);
    chk_small("sat_pos", 67108863, 67108863, 7, 15);
    set_small(67108863, -67108864, 0);
    do_run(0, 0);
    chk_small("sat_neg", -67108864, -67108864, 7, 15);
    // reset one cycle after the first write aborts the pass
    set_small(256, 256, 0);
    cur = 0;
    @(negedge clk); run_x = 1;
    @(negedge clk); run_x = 0;
    k = 0;
    while (!we_a && k < 50) begin @(negedge clk); k++; end
    chk("abort_first_we", we_a, 1);
    @(negedge clk); reset = 1;
    @(negedge clk); reset = 0;
    chk("abort_result", res_a, 0);
    chk("abort_waddr", wad_a, 0);
    chk("abort_we", we_a, 0);
    chk("abort_done", dn_a, 0);
    chk("abort_vaddr", va_a, 0);
    chk("abort_wtaddr", wa_a, 0);
    chk("abort_baddr", ba_a, 0);
    cnt = 0;
    repeat (30) begin @(negedge clk); cnt += int'(we_a) + int'(dn_a); end
    chk("abort_quiet", cnt, 0);
    do_run(0, 0);
    chk_small("after_abort", 1024, 1024, 7, 15);
    // run re-pulsed during FETCH and WRITE is ignored
    do_run(0, 1);
    chk_small("repulse", 1024, 1024, 7, 15);
    // latency 3: same results, 8-cycle neuron period
    do_run(1, 0);
    chk_small("lat3", 1024, 1024, 8, 17);
    // default 50x10 with random Q.8 data, larger weights on the last rows
    for (int i = 0; i < 50; i++) vd[i] = 27'(int'($urandom_range(0, 16383)) - 8192);
    for (int i = 0; i < 500; i++)
      wm[i] = i >= 400 ? 27'(int'($urandom_range(0, 262143)) - 131072) : 27'(int'($urandom_range(0, 16383)) - 8192);
    for (int i = 0; i < 10; i++) bd[i] = 27'(int'($urandom_range(0, 65535)) - 32768);
    do_run(2, 0);
    chk("full_nwrites", nw, 10);
    for (int j = 0; j < 10; j++) begin
      chk($sformatf("full_addr%0d", j), rec_a[j], j);
      chk($sformatf("full_res%0d", j), rec_d[j], gold(j));
    end
    chk("full_done_lat", done_k, 531);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
